// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl
// Iteration scheduler for a flooding LDPC decoder core. For each frame it
// loads the variable-node array with channel LLRs, then alternates check-node
// and variable-node phases. After every iteration it checks the syndrome of
// the hard decisions. It stops on convergence, on MAX_ITER, or on abort.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   start        begin a frame; only looked at in IDLE
//   abort        end the current frame early; only looked at while busy
//   syndrome_ok  all parity checks satisfied; only looked at in CHECK
//   vnu_init     one-cycle strobe: VNUs load Q and P_sample from L
//   cnu_en       check-node update enable
//   vnu_en       variable-node update enable
//   hd_latch     one-cycle strobe: capture P as the decoded word
//   busy         high in every state except IDLE
//   done         one-cycle frame-completion pulse
//   converged    1 = last frame ended on syndrome_ok
//   iter_count   completed iterations of the current/last frame
//   dbg_state    current FSM state encoding, for checkers
//
// Host handshake: start is a level request. It is accepted on a rising edge
// where the controller is in IDLE, and it is ignored (not queued) while busy.
// Each accepted start produces exactly one done pulse, together with
// hd_latch. The only exception is a reset, which ends the frame with no pulse.
// converged and iter_count are valid from the done cycle until the next
// frame starts.

module ldpc_iter_ctrl #(
  parameter int MAX_ITER = 10,
  parameter int CNU_CYC  = 1,
  parameter int VNU_CYC  = 1,
  parameter int ITER_W   = 4,
  parameter int PH_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              syndrome_ok,
  output logic              vnu_init,
  output logic              cnu_en,
  output logic              vnu_en,
  output logic              hd_latch,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CNU   = 3'd2,
    S_VNU   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [PH_W-1:0]   CNU_LAST = PH_W'(CNU_CYC - 1);
  localparam logic [PH_W-1:0]   VNU_LAST = PH_W'(VNU_CYC - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;

  // Strobe/enable outputs are registered copies of what the next state
  // decodes to. This keeps them glitch-free and aligned with state_q.
  logic vnu_init_q, cnu_en_q, vnu_en_q, hd_latch_q, busy_q, done_q;
  logic vnu_init_d, cnu_en_d, vnu_en_d, hd_latch_d, busy_d, done_d;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        iter_d  = '0;
        conv_d  = 1'b0;
        ph_d    = '0;
        state_d = abort ? S_DONE : S_CNU;
      end
      S_CNU: begin
        if (abort) begin
          conv_d  = 1'b0;
          ph_d    = '0;
          state_d = S_DONE;
        end else if (ph_q == CNU_LAST) begin
          ph_d    = '0;
          state_d = S_VNU;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_VNU: begin
        // abort wins over the terminal count, so an interrupted phase is
        // never counted as a completed iteration.
        if (abort) begin
          conv_d  = 1'b0;
          ph_d    = '0;
          state_d = S_DONE;
        end else if (ph_q == VNU_LAST) begin
          ph_d    = '0;
          iter_d  = (iter_q == ITER_MAX) ? iter_q : iter_q + ITER_W'(1);
          state_d = S_CHECK;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_CHECK: begin
        // iter_q here already includes the iteration that just finished.
        if (abort) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else if (syndrome_ok) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (iter_q == ITER_MAX) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_CNU;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  always_comb begin
    vnu_init_d = (state_d == S_INIT);
    cnu_en_d   = (state_d == S_CNU);
    vnu_en_d   = (state_d == S_VNU);
    hd_latch_d = (state_d == S_DONE);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      iter_q     <= '0;
      conv_q     <= 1'b0;
      vnu_init_q <= 1'b0;
      cnu_en_q   <= 1'b0;
      vnu_en_q   <= 1'b0;
      hd_latch_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      iter_q     <= iter_d;
      conv_q     <= conv_d;
      vnu_init_q <= vnu_init_d;
      cnu_en_q   <= cnu_en_d;
      vnu_en_q   <= vnu_en_d;
      hd_latch_q <= hd_latch_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign vnu_init   = vnu_init_q;
  assign cnu_en     = cnu_en_q;
  assign vnu_en     = vnu_en_q;
  assign hd_latch   = hd_latch_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign converged  = conv_q;
  assign iter_count = iter_q;
  assign dbg_state  = state_q;

endmodule
